// File: rtl/n_mem_loader.sv
// Runtime loader for the ModExp modulus RAM: streams words in LSW-first,
// then reads them all back through the registered RAM port and checks a running sum.
module n_mem_loader #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter int unsigned NUM_WORDS    = 128,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0]        wr_cnt;
  logic [CNT_W-1:0]        rd_cnt;
  logic [CNT_W-1:0]        smp_cnt;
  logic [DATA_WIDTH-1:0]   load_sum;
  logic [DATA_WIDTH-1:0]   rd_sum;
  logic                    rd_pend;
  logic [READ_LATENCY-1:0] tags;

  logic                    xfer_c;
  logic                    last_wr_c;
  logic                    rd_issue_c;
  logic                    sample_c;
  logic                    last_smp_c;

  logic                    in_ready_d;
  logic                    busy_d;
  logic                    done_d;
  logic                    mem_wren_d;
  logic [ADDR_WIDTH-1:0]   mem_address_d;
  logic [DATA_WIDTH-1:0]   mem_data_d;

  // abort wins over a same-cycle transfer, read issue or sample
  assign xfer_c     = (state == S_LOAD) && in_valid && in_ready && !abort;
  assign last_wr_c  = xfer_c && (wr_cnt == LAST_IDX);
  assign rd_issue_c = (state == S_VERIFY) && !abort && (rd_cnt < TOTAL);
  assign sample_c   = (state == S_VERIFY) && !abort && tags[READ_LATENCY-1];
  assign last_smp_c = sample_c && (smp_cnt == LAST_IDX);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_LOAD;
      S_LOAD:   if (abort) next_state = S_IDLE;
                else if (last_wr_c) next_state = S_VERIFY;
      S_VERIFY: if (abort) next_state = S_IDLE;
                else if (last_smp_c) next_state = S_FINISH;
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    in_ready_d    = (next_state == S_LOAD);
    busy_d        = (next_state == S_LOAD) || (next_state == S_VERIFY);
    done_d        = (next_state == S_FINISH);
    mem_wren_d    = xfer_c;
    mem_address_d = mem_address;
    mem_data_d    = mem_data;
    if (xfer_c) begin
      mem_address_d = ADDR_WIDTH'(wr_cnt);
      mem_data_d    = in_data;
    end else if (rd_issue_c) begin
      mem_address_d = ADDR_WIDTH'(rd_cnt);
    end
  end

  // Output registers, counters, sums and the read-tag delay line
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      error       <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      smp_cnt     <= '0;
      load_sum    <= '0;
      rd_sum      <= '0;
      rd_pend     <= 1'b0;
      tags        <= '0;
    end else begin
      in_ready    <= in_ready_d;
      busy        <= busy_d;
      done        <= done_d;
      mem_wren    <= mem_wren_d;
      mem_address <= mem_address_d;
      mem_data    <= mem_data_d;

      if (state == S_IDLE && start) begin
        wr_cnt   <= '0;
        rd_cnt   <= '0;
        smp_cnt  <= '0;
        load_sum <= '0;
        rd_sum   <= '0;
        error    <= 1'b0;
      end
      if (xfer_c) begin
        wr_cnt   <= wr_cnt + CNT_W'(1);
        load_sum <= load_sum + in_data;
      end
      if (rd_issue_c) rd_cnt <= rd_cnt + CNT_W'(1);
      if (sample_c) begin
        smp_cnt <= smp_cnt + CNT_W'(1);
        rd_sum  <= rd_sum + mem_q;
      end
      if (state == S_FINISH) error <= (rd_sum != load_sum);

      // rd_pend marks a read address on the bus; tags age it until mem_q is valid
      if (abort || state != S_VERIFY) begin
        rd_pend <= 1'b0;
        tags    <= '0;
      end else begin
        rd_pend <= rd_issue_c;
        tags    <= READ_LATENCY'({tags, rd_pend});
      end
    end
  end

endmodule

// File: tb/tb_n_mem_loader.sv
// Directed bench for n_mem_loader: RAM model with registered read path,
// expected-write queue and timing model checked on every falling edge.
module tb_n_mem_loader;

  localparam int NW = 128;

  logic        clock = 1'b0;
  logic        reset, start, abort, in_valid;
  logic [31:0] in_data;
  logic        in_ready, mem_wren, busy, done, error;
  logic [6:0]  mem_address;
  logic [31:0] mem_data, q;

  n_mem_loader dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(q), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t  wq[$];
  int   checks = 0, failures = 0, cyc = 0;
  int   exp_done = -1, rd_base = -1, rd_lim = -1, last_done = -1;
  int   wr_seen = 0, start_cyc = 0;
  bit   chk_en = 0, corrupt_en = 0;
  logic exp_err = 1'b0;

  logic [31:0] ram [0:NW-1];
  logic [6:0]  a1;

  // Single-port RAM: address register then output register, word 57 optionally corrupted
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_wren) ram[mem_address] <= mem_data;
    a1 <= mem_address;
    q  <= ram[a1] ^ {31'd0, corrupt_en && (a1 == 7'd57)};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model state
  always @(negedge clock) begin : cmp
    wr_t w;
    if (chk_en) begin
      if (mem_wren) begin
        if (wq.size() == 0) chk("spurious_wren", 1, 0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", 64'(mem_address), 64'(w.a));
          chk("wr_data", 64'(mem_data), 64'(w.d));
          wr_seen++;
        end
      end
      if (cyc >= rd_base && cyc < rd_lim) begin
        chk("rd_addr", 64'(mem_address), 64'(cyc - rd_base));
        chk("rd_no_wren", 64'(mem_wren), 0);
      end
      chk("done", 64'(done), 64'(cyc == exp_done));
      if (done) last_done = cyc;
      if (exp_done > 0 && cyc == exp_done - 1) chk("busy_verify", 64'(busy), 1);
      if (cyc == exp_done) chk("busy_finish", 64'(busy), 0);
      if (exp_done > 0 && cyc == exp_done + 1) chk("error_result", 64'(error), 64'(exp_err));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    chk("error_hold", 64'(error), 64'(exp_err));
    last_done = -1;
    wr_seen   = 0;
    start_cyc = cyc;
    start     = 1'b1;
    step();
    start   = 1'b0;
    exp_err = 1'b0;
    chk("error_clear", 64'(error), 0);
    chk("busy_load", 64'(busy), 1);
  endtask

  // Feed words until stop_at have been accepted; the final word arms the verify model
  task automatic run_load(input bit throttle, input int stop_at);
    int i = 0;
    int t = 0;
    bit rdy_ok = 1'b1;
    while (i < stop_at) begin
      in_valid = throttle ? (t % 3 == 0) : 1'b1;
      in_data  = 32'(i) * 32'h0101_0101;
      if (in_ready !== 1'b1) rdy_ok = 1'b0;
      if (in_valid) begin
        wq.push_back({7'(i), in_data});
        if (i == NW - 1) begin
          rd_base  = cyc + 2;
          rd_lim   = cyc + 2 + NW;
          exp_done = cyc + NW + 4;
        end
        i++;
      end
      t++;
      step();
    end
    in_valid = 1'b0;
    chk("in_ready_load", 64'(rdy_ok), 1);
  endtask

  task automatic wait_done();
    while (cyc < exp_done + 2) step();
    chk("done_cycle", 64'(last_done), 64'(exp_done));
    chk("writes_drained", 64'(wq.size()), 0);
  endtask

  task automatic full_run(input bit throttle);
    do_start();
    run_load(throttle, NW);
    chk("in_ready_verify", 64'(in_ready), 0);
    wait_done();
    chk("write_count", 64'(wr_seen), NW);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) step();
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_mem_wren", 64'(mem_wren), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_error", 64'(error), 0);
    chk("rst_addr", 64'(mem_address), 0);
    chk("rst_data", 64'(mem_data), 0);
    step();

    // Back-to-back load: done lands 2*128+4 cycles after the start cycle
    full_run(1'b0);
    chk("start_to_done", 64'(last_done - start_cyc), 260);
    chk("error_clean", 64'(error), 0);

    // Throttled source 1,0,0,...
    full_run(1'b1);

    // Corrupted readback of word 57; error holds until the next start
    corrupt_en = 1'b1;
    do_start();
    exp_err = 1'b1;
    run_load(1'b0, NW);
    wait_done();
    repeat (5) step();
    chk("error_held", 64'(error), 1);
    corrupt_en = 1'b0;

    // Abort during LOAD after 40 words, with a word offered in the abort cycle
    do_start();
    run_load(1'b0, 40);
    abort = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_ld_in_ready", 64'(in_ready), 0);
    chk("abort_ld_busy", 64'(busy), 0);
    chk("abort_ld_wren", 64'(mem_wren), 0);
    repeat (8) step();
    chk("abort_ld_drained", 64'(wq.size()), 0);
    full_run(1'b0);

    // Abort during VERIFY with reads in flight
    do_start();
    run_load(1'b0, NW);
    while (cyc < rd_base + 50) step();
    abort    = 1'b1;
    rd_lim   = cyc + 1;
    exp_done = -1;
    step();
    abort = 1'b0;
    chk("abort_vf_busy", 64'(busy), 0);
    chk("abort_vf_in_ready", 64'(in_ready), 0);
    repeat (10) step();
    chk("abort_vf_no_done", 64'(last_done), 64'(-1));
    chk("abort_vf_error", 64'(error), 0);
    full_run(1'b0);

    // Reset together with start in the middle of a load
    do_start();
    run_load(1'b0, 20);
    reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678;
    exp_done = -1;
    step();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    exp_err = 1'b0;
    chk("rr_in_ready", 64'(in_ready), 0);
    chk("rr_mem_wren", 64'(mem_wren), 0);
    chk("rr_busy", 64'(busy), 0);
    chk("rr_done", 64'(done), 0);
    chk("rr_error", 64'(error), 0);
    chk("rr_addr", 64'(mem_address), 0);
    chk("rr_data", 64'(mem_data), 0);
    step();
    full_run(1'b0);
    chk("final_error", 64'(error), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
